// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared types and constants for the SAD search engine
package sad_pkg;

  // Search controller states; encoding is fixed so state dumps are readable.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CMP   = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // 256 pixels x 8-bit absolute difference fits in 16 bits.
  localparam int SAD_W_DEF = 16;

  // Initial "no match yet" value for the running minimum.
  localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

endpackage

// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - running minimum SAD and its candidate index
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int SAD_W = SAD_W_DEF,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic [SAD_W-1:0] value,
  input  logic [IDX_W-1:0] idx,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx
);

  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;

  // Strict less-than so a tie keeps the earlier candidate; clear wins over valid.
  always_comb begin
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    if (clear) begin
      best_sad_d = '1;
      best_idx_d = '0;
    end else if (valid && (value < best_sad_q)) begin
      best_sad_d = value;
      best_idx_d = idx;
    end
  end

  // Best-match registers, reset to "nothing found".
  always_ff @(posedge clk) begin
    if (!rst) begin
      best_sad_q <= '1;
      best_idx_q <= '0;
    end else begin
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

endmodule

// File: rtl/sad_search_ctrl.sv
// rtl/sad_search_ctrl.sv - candidate sweep controller above the SAD datapath
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int NUM_CAND = 16,
  parameter int SAD_W    = SAD_W_DEF,
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             sad_go,
  input  logic             sad_done,
  input  logic [SAD_W-1:0] sad_val,
  output logic [IDX_W-1:0] cand_idx,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cand_q, cand_d;
  logic [SAD_W-1:0] val_q, val_d;
  logic             trk_clear;
  logic             trk_valid;

  // Next-state, candidate stepping and tracker strobes; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    val_d     = val_q;
    trk_clear = 1'b0;
    trk_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          cand_d    = '0;
          trk_clear = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (sad_done) begin
          val_d   = sad_val;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        trk_valid = 1'b1;
        if (val_q == '0) begin
          state_d = ST_FIN;
        end else if (cand_q == LAST_IDX) begin
          state_d = ST_FIN;
        end else begin
          cand_d  = cand_q + 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      cand_d    = cand_q;
      val_d     = val_q;
      trk_valid = 1'b0;
    end
  end

  // State, candidate index and latched SAD result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      val_q   <= val_d;
    end
  end

  sad_min_tracker #(
    .SAD_W (SAD_W),
    .IDX_W (IDX_W)
  ) u_min_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (trk_clear),
    .valid    (trk_valid),
    .value    (val_q),
    .idx      (cand_q),
    .best_sad (best_sad),
    .best_idx (best_idx)
  );

  assign sad_go   = (state_q == ST_ISSUE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FIN);
  assign cand_idx = cand_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb/tb_sad_search_ctrl.sv - self-checking bench for sad_search_ctrl
module tb_sad_search_ctrl;

  localparam int NC = 4;
  localparam int L  = 5;

  typedef struct {
    logic [3:0][15:0] resp;
    logic [15:0]      exp_sad;
    logic [1:0]       exp_idx;
    int               exp_gos;
  } vec_t;

  typedef struct {
    logic [15:0] sad;
    logic [1:0]  idx;
    int          lat;
    int          gos;
    logic [1:0]  last_idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sad_go;
  logic        sad_done = 1'b0;
  logic [15:0] sad_val = 16'd0;
  logic [1:0]  cand_idx;
  logic        busy;
  logic        done;
  logic [15:0] best_sad;
  logic [1:0]  best_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int go_cnt = 0;
  int cnt = 0;
  logic [1:0]  cap_idx = 2'd0;
  logic [15:0] resp_tab [NC];
  exp_t        sb [$];
  vec_t        vecs [6];

  sad_search_ctrl #(.NUM_CAND(NC), .SAD_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sad_go(sad_go),
    .sad_done(sad_done), .sad_val(sad_val), .cand_idx(cand_idx), .busy(busy),
    .done(done), .best_sad(best_sad), .best_idx(best_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // SAD unit model: go in cycle c -> sad_done in cycle c+L with resp[cand_idx at go].
  always @(negedge clk) begin
    sad_done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        sad_done = 1'b1;
        sad_val  = resp_tab[cap_idx];
      end
    end
    if (sad_go) begin
      cnt     = L;
      cap_idx = cand_idx;
      go_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] r0, r1, r2, r3,
                              input logic [15:0] s, input logic [1:0] i, input int g);
    vec_t v;
    v.resp = {r3, r2, r1, r0};
    v.exp_sad = s;
    v.exp_idx = i;
    v.exp_gos = g;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < NC; i++) resp_tab[i] = v.resp[i];
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic run_search(input vec_t v, input bit abort_too, input bit repulse);
    exp_t e;
    int   s_edge;
    int   go_base;
    int   n;
    load(v);
    e.sad = v.exp_sad;
    e.idx = v.exp_idx;
    e.gos = v.exp_gos;
    e.lat = 1 + v.exp_gos * (L + 2);
    e.last_idx = 2'(v.exp_gos - 1);
    sb.push_back(e);
    start   = 1'b1;
    abort   = abort_too;
    go_base = go_cnt;
    s_edge  = cyc;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("first_busy", busy, 1);
    chk("first_go", sad_go, 1);
    chk("init_best_sad", best_sad, 16'hFFFF);
    chk("init_best_idx", best_idx, 0);
    chk("init_cand", cand_idx, 0);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      start = (repulse && n == 10);
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=0 exp=1");
    end else begin
      chk("latency", cyc - s_edge, e.lat);
      chk("best_sad", best_sad, e.sad);
      chk("best_idx", best_idx, e.idx);
      chk("go_pulses", go_cnt - go_base, e.gos);
      chk("last_cand", cand_idx, e.last_idx);
    end
    @(negedge clk);
    chk("done_single", done, 0);
    chk("idle_after", busy, 0);
  endtask

  task automatic wait_go_at(input logic [1:0] idx);
    int n = 0;
    while (!(sad_go && cand_idx == idx) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(sad_go && cand_idx == idx)) begin
      checks++;
      failures++;
      $display("FAIL go_timeout got=%0d exp=%0d", cand_idx, idx);
    end
  endtask

  initial begin
    bit bad;
    vecs[0] = mk(16'd40, 16'd25, 16'd25, 16'd30, 16'd25, 2'd1, 4);
    vecs[1] = mk(16'd50, 16'd0, 16'd9, 16'd9, 16'd0, 2'd1, 2);
    vecs[2] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'd0, 4);
    vecs[3] = mk(16'd10, 16'd20, 16'd30, 16'd5, 16'd5, 2'd3, 4);
    vecs[4] = mk(16'd0, 16'd40, 16'd40, 16'd40, 16'd0, 2'd0, 1);
    vecs[5] = mk(16'd7, 16'd7, 16'd3, 16'd3, 16'd3, 2'd2, 4);

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_go", sad_go, 0);
    chk("rst_done", done, 0);
    chk("rst_cand", cand_idx, 0);
    chk("rst_best_idx", best_idx, 0);
    chk("rst_best_sad", best_sad, 16'hFFFF);
    rst = 1'b1;
    @(negedge clk);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", busy, 0);

    // Vector table: first start carries a simultaneous abort, all run back-to-back.
    for (int i = 0; i < 6; i++) run_search(vecs[i], (i == 0), (i == 3));

    repeat (3) @(negedge clk);
    chk("hold_best_sad", best_sad, 16'd3);
    chk("hold_cand", cand_idx, 3);

    // Abort during WAIT of candidate 2; the late sad_done must be ignored.
    load(mk(16'd70, 16'd60, 16'd50, 16'd40, 16'd0, 2'd0, 0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_go_at(2'd2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) bad = 1'b1;
    end
    chk("abort_late_done", bad, 0);
    chk("abort_best_sad", best_sad, 16'd60);
    chk("abort_best_idx", best_idx, 1);
    chk("abort_cand", cand_idx, 2);

    // Reset asserted in the CMP cycle of candidate 1.
    load(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_go_at(2'd1);
    repeat (L + 1) @(negedge clk);
    chk("pre_rst_cand", cand_idx, 1);
    chk("pre_rst_best", best_sad, 16'd40);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_go", sad_go, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cand", cand_idx, 0);
    chk("midrst_best_sad", best_sad, 16'hFFFF);
    chk("midrst_best_idx", best_idx, 0);
    repeat (10) @(negedge clk);

    run_search(vecs[0], 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end

endmodule

// File: doc/sad_search_ctrl.md
# sad_search_ctrl

Sequencing controller that runs the existing SAD datapath over a set of candidate block positions and tracks the best (minimum) match. It sits above the SAD unit's own FSM: it pulses that unit's `go`, waits for its result, steps the candidate index that drives the address generator, and reports the minimum SAD and its candidate index. It is the top-level search engine for block-matching motion estimation.

## Interface

**Parameters**
- `NUM_CAND`, default 16: number of candidate positions per search. Range 2..256.
- `SAD_W`, default 16: width of the SAD result (256 pixels × 8-bit absolute difference fits in 16 bits).
- `IDX_W`, default `$clog2(NUM_CAND)`: width of the candidate index.

**Ports**
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-low reset (`rst==0` at a rising edge resets).
- `start`, in, 1: begin a search. Accepted only in IDLE.
- `abort`, in, 1: cancel a running search.
- `sad_go`, out, 1: single-cycle pulse to the SAD unit's `go`.
- `sad_done`, in, 1: single-cycle pulse from the SAD unit in the cycle `sad_val` is valid.
- `sad_val`, in, `SAD_W`: SAD result for the current candidate.
- `cand_idx`, out, `IDX_W`: current candidate index to the address generator. Held stable from ISSUE through CMP.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: single-cycle pulse when a search completes normally.
- `best_sad`, out, `SAD_W`: minimum SAD found so far.
- `best_idx`, out, `IDX_W`: candidate index of `best_sad`.

## Operation

**State machine:** IDLE, ISSUE, WAIT, CMP, FIN.
- **IDLE**
  - `start=1`: go to ISSUE; `cand_idx←0`, `best_sad←{SAD_W{1}}`, `best_idx←0`.
  - Otherwise stay in IDLE.
  - `sad_done` is ignored in IDLE.
- **ISSUE**
  - `sad_go=1` for exactly this cycle, then go to WAIT.
- **WAIT**
  - Hold until `sad_done=1`; then latch `sad_val` and go to CMP.
  - There is no timeout.
- **CMP**
  - If latched value < `best_sad` (strict less-than), update `best_sad` and `best_idx←cand_idx`. On a tie, the earlier index is kept.
  - Latched value == 0: go to FIN (early exit; perfect match).
  - Else if `cand_idx==NUM_CAND-1`: go to FIN.
  - Else: `cand_idx←cand_idx+1` and go to ISSUE.
- **FIN**
  - `done=1` for this cycle, then go to IDLE.
  - `best_sad`, `best_idx` and `cand_idx` hold until the next accepted `start`.

**Boundary and corner cases**
- `abort` in any non-IDLE state: go to IDLE next cycle. No `done`. `best_*` hold their partial values.
- `abort` has priority over every other transition, including CMP→FIN in the same cycle.
- `abort` in IDLE has no effect.
- `start` while busy is ignored.
- `start` and `abort` together in IDLE: `start` wins.
- A late `sad_done` arriving after an abort lands in IDLE and is ignored.
- `cand_idx` never exceeds `NUM_CAND-1`; there is no wrap-around.
- Comparison is unsigned, full `SAD_W` width.

## Timing

- **Reset values:** state IDLE, `sad_go=0`, `busy=0`, `done=0`, `cand_idx=0`, `best_idx=0`, `best_sad` all ones.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.
- `start` sampled at edge 0: `busy` and `sad_go` are high in cycle 1.
- `sad_done` in cycle t: CMP in cycle t+1. Then either ISSUE in t+2 (`sad_go` high) or FIN in t+2 (`done` high).
- `best_*` update at the end of CMP and are visible no later than the `done` cycle.
- With a SAD unit latency of L cycles (go to done):
  - Per-candidate period is L+2 cycles.
  - Full search with no early exit: `done` at cycle 1 + NUM_CAND·(L+2) after the start edge.
- Reset mid-search: state IDLE and reset values on the next edge, regardless of state.

## Structure

- **Shared package `sad_pkg`:**
  - state enum (IDLE=0, ISSUE=1, WAIT=2, CMP=3, FIN=4; 3 bits);
  - default `SAD_W` constant;
  - the `SAD_MAX` all-ones constant.
- **Sub-module `sad_min_tracker`:** holds `best_sad`/`best_idx`. Inputs are clear, valid, value and idx; it performs the strict-less update. The controller instantiates it once.

## Test plan

- **Basic search:** `NUM_CAND=4`, SAD model L=5 returning 40, 25, 25, 30 → `best_sad=25`, `best_idx=1`; `done` exactly 1 + 4·7 = 29 cycles after `start`; four `sad_go` pulses.
- **Early exit:** returns 50, 0, 9, 9 → `done` after the second candidate; `best_sad=0`, `best_idx=1`; only two `sad_go` pulses.
- **Abort:** abort during WAIT of candidate 2 (returns 70, 60, …) → IDLE next cycle; no `done`; `best_sad=60`, `best_idx=1`; a later `sad_done` is ignored.
- **Start while busy / reset:** `start` re-pulsed mid-search causes no restart. `rst=0` during CMP → next cycle all reset values, `busy=0`.
- **Worst-case values:** all candidates return `16'hFFFF` → `best_sad=16'hFFFF`, `best_idx=0`; `cand_idx` stops at `NUM_CAND-1`.
- **Back-to-back searches:** `start` again in the cycle after `done` → `best_sad` re-initialised to all ones; second search result independent of the first.
